axi_burst_read_ram: RTL

Parametrised AXI4 read-channel slave backed by an internal word RAM. It accepts one AR burst at a time and returns arlen+1 R beats with full FIXED/INCR burst address generation, size-scaled stepping, and error responses. A sideband preload write port fills the RAM. It is the successor to the single-configuration slave RAM and is the read target for the interconnect and DMA benches.

---
 rtl/axi_burst_read_ram.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/axi_burst_read_ram.sv
// AXI4 read-channel slave over a preloadable word RAM; serves one FIXED/INCR(/WRAP) AR burst at a time.
// Latency: first R beat the cycle after the AR handshake, then one beat per cycle; one idle cycle between bursts.
// Backpressure: rvalid && !rready holds rdata/rresp/rlast; arready low during a burst. WRAP needs AXI_BURST_READ_RAM_WRAP_EN.
module axi_burst_read_ram #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [ADDRESS_WIDTH-1:0] araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic [1:0]               arburst,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [DATA_WIDTH-1:0]    rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     rvalid,
    input  logic                     rready,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data
);
    localparam int     BYTES     = DATA_WIDTH / 8;
    localparam int     SIZE_MAX  = $clog2(BYTES);
    localparam int     IDX_W     = $clog2(DEPTH);
    localparam longint MAP_BYTES = longint'(DEPTH) * longint'(BYTES);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Burst context captured at the AR handshake; cur_addr is the address of the beat on the bus.
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [7:0]               len_q;
    logic [7:0]               cnt;
    logic [2:0]               size_q;
    logic [1:0]               burst_q;
    logic                     slverr_q;
`ifdef AXI_BURST_READ_RAM_WRAP_EN
    logic [ADDRESS_WIDTH-1:0] wmask_q;
`endif

    logic                     ar_hs;
    logic                     r_hs;
    logic                     fetch;
    logic                     slverr_in;
    logic                     wrap_ok;
    logic [ADDRESS_WIDTH-1:0] step;
    logic [ADDRESS_WIDTH-1:0] size_mask;
    logic [ADDRESS_WIDTH-1:0] next_addr;
    logic [ADDRESS_WIDTH-1:0] fetch_addr;
    logic [7:0]               fetch_cnt;
    logic [7:0]               fetch_len;
    logic                     fetch_slverr;
    logic                     fetch_decerr;
    logic [IDX_W-1:0]         fetch_idx;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and beat-fetch control: a fetch loads the beat that will be on the bus next cycle.
    always_comb begin
        state_nxt = state;
        ar_hs     = 1'b0;
        r_hs      = rvalid && rready;
        fetch     = 1'b0;
        case (state)
            IDLE: begin
                ar_hs = arvalid && arready;
                fetch = ar_hs;
                if (ar_hs) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                fetch = r_hs && !rlast;
                if (r_hs && rlast) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Whole-burst error check on the incoming AR request.
    always_comb begin
        wrap_ok = 1'b0;
`ifdef AXI_BURST_READ_RAM_WRAP_EN
        wrap_ok = ((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15))
               && ((araddr & ((ADDRESS_WIDTH'(1) << arsize) - ADDRESS_WIDTH'(1))) == '0);
`endif
        slverr_in = (int'(arsize) > SIZE_MAX)
                 || (arburst == 2'b11)
                 || ((arburst == 2'b10) && !wrap_ok);
    end

    // Address of the beat after cur_addr; INCR realigns an unaligned start down to the beat size.
    always_comb begin
        step      = ADDRESS_WIDTH'(1) << size_q;
        size_mask = step - ADDRESS_WIDTH'(1);
        case (burst_q)
            2'b01:   next_addr = (cur_addr & ~size_mask) + step;
`ifdef AXI_BURST_READ_RAM_WRAP_EN
            2'b10:   next_addr = (cur_addr & ~wmask_q) | ((cur_addr + step) & wmask_q);
`endif
            default: next_addr = cur_addr;
        endcase
    end

    // Select the beat being fetched: the AR start address, or the next beat of the current burst.
    always_comb begin
        fetch_addr   = ar_hs ? araddr    : next_addr;
        fetch_cnt    = ar_hs ? 8'd0      : cnt + 8'd1;
        fetch_len    = ar_hs ? arlen     : len_q;
        fetch_slverr = ar_hs ? slverr_in : slverr_q;
        fetch_decerr = 64'(fetch_addr) >= MAP_BYTES;
        fetch_idx    = IDX_W'(fetch_addr >> SIZE_MAX);
    end

    // Sideband preload; a same-cycle fetch of the same word sees the old contents.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Burst context capture and registered R channel.
    always_ff @(posedge aclk) begin
        if (areset) begin
            arready  <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= RESP_OKAY;
            rdata    <= '0;
            cnt      <= 8'd0;
            cur_addr <= '0;
            len_q    <= 8'd0;
            size_q   <= 3'd0;
            burst_q  <= 2'b00;
            slverr_q <= 1'b0;
`ifdef AXI_BURST_READ_RAM_WRAP_EN
            wmask_q  <= '0;
`endif
        end else begin
            arready <= (state_nxt == IDLE);
            if (ar_hs) begin
                len_q    <= arlen;
                size_q   <= arsize;
                burst_q  <= arburst;
                slverr_q <= slverr_in;
`ifdef AXI_BURST_READ_RAM_WRAP_EN
                wmask_q  <= ADDRESS_WIDTH'(((32'(arlen) + 32'd1) << arsize) - 32'd1);
`endif
            end
            if (fetch) begin
                cur_addr <= fetch_addr;
                cnt      <= fetch_cnt;
                rvalid   <= 1'b1;
                rlast    <= (fetch_cnt == fetch_len);
                if (fetch_slverr) begin
                    rresp <= RESP_SLVERR;
                    rdata <= '0;
                end else if (fetch_decerr) begin
                    rresp <= RESP_DECERR;
                    rdata <= '0;
                end else begin
                    rresp <= RESP_OKAY;
                    rdata <= mem[fetch_idx];
                end
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end
endmodule
